// File: rtl/crc_parallel.sv
// Byte-parallel CRC-16 generator: absorbs one byte per clock, then streams the
// 16-bit result out high byte first on the 8-bit crc_out bus.
module crc_parallel #(
  parameter logic [15:0] POLY    = 16'h1021,
  parameter logic [15:0] INIT    = 16'hFFFF,
  parameter logic [15:0] XOR_OUT = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       d_finish,
  input  logic [7:0] crc_in,
  output logic [7:0] crc_out
);

  typedef enum logic [2:0] {IDLE, CALC, OUT_HI, OUT_LO, DONE} state_t;

  localparam logic [15:0] R_EMPTY = INIT ^ XOR_OUT;

  // Unrolled at elaboration: eight shift/XOR steps collapse into one XOR network.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  state_t      state;
  logic [15:0] crc_q;
  logic [15:0] crc_fresh, crc_next, crc_res;

  always_comb begin
    crc_fresh = crc_byte(INIT, crc_in);
    crc_next  = crc_byte(crc_q, crc_in);
    crc_res   = crc_q ^ XOR_OUT;
  end

  // After d_finish the CRC register itself holds the final result R, so DONE
  // can re-emit it without another XOR_OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q   <= INIT;
      state   <= IDLE;
      crc_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            crc_q   <= crc_fresh;
            crc_out <= 8'h00;
            state   <= CALC;
          end else if (d_finish) begin
            crc_q   <= R_EMPTY;
            crc_out <= R_EMPTY[15:8];
            state   <= OUT_HI;
          end
        end
        CALC: begin
          if (load) begin
            crc_q <= crc_next;
          end else if (d_finish) begin
            crc_q   <= crc_res;
            crc_out <= crc_res[15:8];
            state   <= OUT_HI;
          end
        end
        OUT_HI: begin
          crc_out <= crc_q[7:0];
          state   <= OUT_LO;
        end
        OUT_LO: state <= DONE;
        DONE: begin
          if (load) begin
            crc_q   <= crc_fresh;
            crc_out <= 8'h00;
            state   <= CALC;
          end else if (d_finish) begin
            crc_out <= crc_q[15:8];
            state   <= OUT_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_parallel.sv
// Directed self-checking bench for crc_parallel (CRC-16/CCITT-FALSE defaults).
module tb_crc_parallel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       d_finish = 1'b0;
  logic [7:0] crc_in = 8'h00;
  logic [7:0] crc_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ascii [0:8];
  logic [7:0] vb [0:3];
  logic [15:0] exp16;

  crc_parallel dut (
    .clk(clk), .rst(rst), .load(load), .d_finish(d_finish),
    .crc_in(crc_in), .crc_out(crc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Bit-serial LFSR reference, one input bit per step, MSB first.
  function automatic logic [15:0] model_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Drive one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic ld, input logic df, input logic [7:0] d);
    load = ld; d_finish = df; crc_in = d;
    @(posedge clk); #1;
    load = 1'b0; d_finish = 1'b0; crc_in = 8'h00;
  endtask

  task automatic send_ascii(input int first, input int last);
    for (int i = first; i <= last; i++) cyc(1'b1, 1'b0, ascii[i]);
  endtask

  task automatic finish_chk(input string tag, input logic [15:0] r);
    cyc(1'b0, 1'b1, 8'h00);
    chk({tag, "_hi"}, crc_out, r[15:8]);
    cyc(1'b0, 1'b0, 8'h00);
    chk({tag, "_lo"}, crc_out, r[7:0]);
    cyc(1'b0, 1'b0, 8'h00);
    chk({tag, "_hold"}, crc_out, r[7:0]);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) ascii[i] = 8'h31 + 8'(i);
    vb[0] = 8'h00; vb[1] = 8'hD9; vb[2] = 8'hAC; vb[3] = 8'hF0;

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load = 1'($urandom); d_finish = 1'($urandom); crc_in = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; load = 1'b0; d_finish = 1'b0; crc_in = 8'h00;
    chk("reset_out", crc_out, 8'h00);

    // Empty frame
    finish_chk("empty", 16'hFFFF);

    // Known vector
    send_ascii(0, 8);
    chk("calc_zero", crc_out, 8'h00);
    finish_chk("check", 16'h29B1);

    // Re-emit from DONE
    finish_chk("reemit", 16'h29B1);

    // Gapped frame
    send_ascii(0, 3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'hEE);
    chk("gap_zero", crc_out, 8'h00);
    send_ascii(4, 8);
    finish_chk("gapped", 16'h29B1);

    // Arbitrary bytes against the serial model
    exp16 = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, vb[i]);
      exp16 = model_byte(exp16, vb[i]);
    end
    finish_chk("vec4", exp16);

    // Back-to-back: B starts from INIT regardless of A
    send_ascii(0, 8);
    finish_chk("frame_a", 16'h29B1);
    cyc(1'b1, 1'b0, 8'h55);
    chk("b_first_load", crc_out, 8'h00);
    cyc(1'b1, 1'b0, 8'hAA);
    exp16 = model_byte(model_byte(16'hFFFF, 8'h55), 8'hAA);
    finish_chk("frame_b", exp16);

    // load + d_finish together: load wins
    send_ascii(0, 7);
    cyc(1'b1, 1'b1, ascii[8]);
    chk("coll_no_out", crc_out, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("coll_idle", crc_out, 8'h00);
    finish_chk("coll", 16'h29B1);

    // Inputs during the output sequence are ignored
    send_ascii(0, 8);
    cyc(1'b0, 1'b1, 8'h00);
    chk("busy_hi", crc_out, 8'h29);
    cyc(1'b1, 1'b1, 8'h77);
    chk("busy_lo", crc_out, 8'hB1);
    cyc(1'b1, 1'b1, 8'h77);
    chk("busy_lo2", crc_out, 8'hB1);
    cyc(1'b0, 1'b0, 8'h00);
    chk("busy_hold", crc_out, 8'hB1);

    // Mid-frame reset
    send_ascii(0, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out", crc_out, 8'h00);
    send_ascii(0, 8);
    finish_chk("midrst", 16'h29B1);

    // Reset during output
    send_ascii(0, 8);
    cyc(1'b0, 1'b1, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("outrst_out", crc_out, 8'h00);
    finish_chk("outrst_empty", 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
